// File: rtl/id_ex_stage_reg_pkg.sv
// mips_pkg: shared types for the ID/EX pipeline boundary.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: ex_ctrl_t control bundle, ALUOP_* encodings, REG_ZERO,
//           stage FSM states and the per-edge capture selector.
package mips_pkg;

   // Decoded control carried from ID into EX. A bubble is all-zero, so
   // reg_write / mem_write can never fire from an empty slot.
   typedef struct packed {
      logic       reg_write;
      logic       mem_to_reg;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic       alu_src;
      logic       reg_dst;
      logic [1:0] alu_op;
   } ex_ctrl_t;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;  // lw / sw / addi address or sum
   localparam logic [1:0] ALUOP_SUB   = 2'b01;  // beq compare
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;  // funct field decides
   localparam logic [1:0] ALUOP_IMM   = 2'b11;  // other immediate ops

   localparam logic [4:0] REG_ZERO    = 5'd0;   // $zero, never a hazard source

   localparam ex_ctrl_t   EX_CTRL_NOP = '0;

   // RUN: normal flow. BUBBLE: one bubble was just inserted; the held ID
   // instruction goes through next, so a second bubble is impossible.
   typedef enum logic {
      RUN    = 1'b0,
      BUBBLE = 1'b1
   } stage_state_e;

   // What the EX register bank does on the coming edge.
   typedef enum logic [1:0] {
      CAP_HOLD   = 2'd0,   // keep current EX contents
      CAP_BUBBLE = 2'd1,   // load an empty slot
      CAP_ID     = 2'd2    // load the ID instruction
   } cap_sel_e;

endpackage

// File: rtl/id_ex_stage_reg_if.sv
// id_ex_stage_reg_if: bundles the ID-side inputs and EX-side outputs of the ID/EX stage.
// Latency: n/a (wiring only).
// Backpressure: hazard_stall travels upstream; ex_stall_in travels in from EX.
// Modports: slave = the stage register, master = whatever drives ID and consumes EX.
// Optional: ID_EX_PERF_EN adds perf_bubble_cnt / perf_flush_cnt.
interface id_ex_stage_reg_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
);
   import mips_pkg::*;

   // ID side
   logic              id_valid;
   ex_ctrl_t          id_ctrl;
   logic              id_uses_rt;
   logic [REG_AW-1:0] id_rs;
   logic [REG_AW-1:0] id_rt;
   logic [REG_AW-1:0] id_rd;
   logic [DATA_W-1:0] id_read_data1;
   logic [DATA_W-1:0] id_read_data2;
   logic [DATA_W-1:0] id_imm_ext;
   logic [DATA_W-1:0] id_pc_plus4;
   logic              flush_in;
   logic              ex_stall_in;

   // EX side
   logic              ex_valid;
   ex_ctrl_t          ex_ctrl;
   logic [REG_AW-1:0] ex_rs;
   logic [REG_AW-1:0] ex_rt;
   logic [REG_AW-1:0] ex_rd;
   logic [REG_AW-1:0] ex_write_register;
   logic [DATA_W-1:0] ex_read_data1;
   logic [DATA_W-1:0] ex_read_data2;
   logic [DATA_W-1:0] ex_imm_ext;
   logic [DATA_W-1:0] ex_pc_plus4;
   logic              hazard_stall;

`ifdef ID_EX_PERF_EN
   logic [31:0]       perf_bubble_cnt;
   logic [31:0]       perf_flush_cnt;
`endif

   modport slave (
`ifdef ID_EX_PERF_EN
      output perf_bubble_cnt, perf_flush_cnt,
`endif
      input  id_valid, id_ctrl, id_uses_rt, id_rs, id_rt, id_rd,
             id_read_data1, id_read_data2, id_imm_ext, id_pc_plus4,
             flush_in, ex_stall_in,
      output ex_valid, ex_ctrl, ex_rs, ex_rt, ex_rd, ex_write_register,
             ex_read_data1, ex_read_data2, ex_imm_ext, ex_pc_plus4,
             hazard_stall
   );

   modport master (
`ifdef ID_EX_PERF_EN
      input  perf_bubble_cnt, perf_flush_cnt,
`endif
      output id_valid, id_ctrl, id_uses_rt, id_rs, id_rt, id_rd,
             id_read_data1, id_read_data2, id_imm_ext, id_pc_plus4,
             flush_in, ex_stall_in,
      input  ex_valid, ex_ctrl, ex_rs, ex_rt, ex_rd, ex_write_register,
             ex_read_data1, ex_read_data2, ex_imm_ext, ex_pc_plus4,
             hazard_stall
   );

endinterface

// File: rtl/id_ex_stage_reg_hazard_detect.sv
// id_ex_hazard_detect: load-use compare between the load in EX and the instruction in ID.
// Latency: combinational.
// Backpressure: none; the result feeds the stage FSM.
// Ports: ex_valid/ex_mem_read/ex_rt describe EX; id_valid/id_uses_rt/id_rs/id_rt describe ID;
//        load_use is high when ID needs a value that the EX load has not produced yet.
module id_ex_hazard_detect
   import mips_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic              ex_valid,
   input  logic              ex_mem_read,
   input  logic [REG_AW-1:0] ex_rt,
   input  logic              id_valid,
   input  logic              id_uses_rt,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   output logic              load_use
);

   logic ex_is_load;
   logic rs_match;
   logic rt_match;

   always_comb begin
      // $zero writes are discarded, so a load targeting it blocks nobody.
      ex_is_load = ex_valid & ex_mem_read & (ex_rt != REG_AW'(REG_ZERO));
      rs_match   = (ex_rt == id_rs);
      // rt only matters when the instruction actually reads it (not for lw/addi).
      rt_match   = id_uses_rt & (ex_rt == id_rt);
      load_use   = ex_is_load & id_valid & (rs_match | rt_match);
   end

endmodule

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with load-use bubble insertion, branch flush and EX stall.
// Latency: 1 cycle ID->EX; a load-use hazard costs exactly one bubble cycle.
// Backpressure: hazard_stall (combinational) freezes PC and IF/ID on a load-use or when ex_stall_in holds EX.
// Ports: clk, rst (async, active-high); bus = id_ex_stage_reg_if.slave carrying ID inputs, EX outputs,
//        flush_in, ex_stall_in and hazard_stall.
// Optional: define ID_EX_PERF_EN for saturating perf_bubble_cnt / perf_flush_cnt.
// Edge priority: rst > flush_in > ex_stall_in > load-use > capture.
module id_ex_stage_reg
   import mips_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic             clk,
   input  logic             rst,
   id_ex_stage_reg_if.slave bus
);

   stage_state_e      state_q;
   stage_state_e      state_d;
   cap_sel_e          cap_sel;
   logic              load_use;
   logic              stall_comb;

   logic              ex_valid_q;
   ex_ctrl_t          ex_ctrl_q;
   logic [REG_AW-1:0] ex_rs_q;
   logic [REG_AW-1:0] ex_rt_q;
   logic [REG_AW-1:0] ex_rd_q;
   logic [REG_AW-1:0] ex_wr_q;
   logic [DATA_W-1:0] ex_rd1_q;
   logic [DATA_W-1:0] ex_rd2_q;
   logic [DATA_W-1:0] ex_imm_q;
   logic [DATA_W-1:0] ex_pc4_q;

   id_ex_hazard_detect #(
      .REG_AW (REG_AW)
   ) u_hazard (
      .ex_valid    (ex_valid_q),
      .ex_mem_read (ex_ctrl_q.mem_read),
      .ex_rt       (ex_rt_q),
      .id_valid    (bus.id_valid),
      .id_uses_rt  (bus.id_uses_rt),
      .id_rs       (bus.id_rs),
      .id_rt       (bus.id_rt),
      .load_use    (load_use)
   );

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      if (bus.flush_in) begin
         state_d = RUN;
      end else if (!bus.ex_stall_in) begin
         case (state_q)
            RUN:     state_d = load_use ? BUBBLE : RUN;
            BUBBLE:  state_d = RUN;
            default: state_d = RUN;
         endcase
      end
   end

   // ---------------- FSM: outputs ----------------
   // A flush redirects the PC anyway, so it does not also request a freeze;
   // the killed instruction is replaced by a bubble even if EX is stalled.
   always_comb begin
      cap_sel    = CAP_HOLD;
      stall_comb = 1'b0;
      if (bus.flush_in) begin
         cap_sel = CAP_BUBBLE;
      end else if (bus.ex_stall_in) begin
         cap_sel    = CAP_HOLD;
         stall_comb = 1'b1;
      end else begin
         case (state_q)
            RUN: begin
               if (load_use) begin
                  cap_sel    = CAP_BUBBLE;
                  stall_comb = 1'b1;
               end else begin
                  cap_sel = CAP_ID;
               end
            end
            BUBBLE:  cap_sel = CAP_ID;
            default: cap_sel = CAP_ID;
         endcase
      end
      // The async clear empties EX and the FSM at once; only a pass-through
      // ex_stall_in could keep the freeze alive, so mask it while in reset.
      if (rst) begin
         stall_comb = 1'b0;
      end
   end

   assign bus.hazard_stall = stall_comb;

   // ---------------- EX register bank ----------------
   // Data registers load on both bubble and capture; with ex_valid=0 and
   // ex_ctrl=0 their contents are irrelevant, which saves a mux level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid_q <= 1'b0;
         ex_ctrl_q  <= EX_CTRL_NOP;
         ex_rs_q    <= '0;
         ex_rt_q    <= '0;
         ex_rd_q    <= '0;
         ex_wr_q    <= '0;
         ex_rd1_q   <= '0;
         ex_rd2_q   <= '0;
         ex_imm_q   <= '0;
         ex_pc4_q   <= '0;
      end else begin
         case (cap_sel)
            CAP_BUBBLE: begin
               ex_valid_q <= 1'b0;
               ex_ctrl_q  <= EX_CTRL_NOP;
            end
            CAP_ID: begin
               ex_valid_q <= bus.id_valid;
               ex_ctrl_q  <= bus.id_valid ? bus.id_ctrl : EX_CTRL_NOP;
            end
            default: ;
         endcase
         if (cap_sel != CAP_HOLD) begin
            ex_rs_q  <= bus.id_rs;
            ex_rt_q  <= bus.id_rt;
            ex_rd_q  <= bus.id_rd;
            ex_wr_q  <= bus.id_ctrl.reg_dst ? bus.id_rd : bus.id_rt;
            ex_rd1_q <= bus.id_read_data1;
            ex_rd2_q <= bus.id_read_data2;
            ex_imm_q <= bus.id_imm_ext;
            ex_pc4_q <= bus.id_pc_plus4;
         end
      end
   end

   assign bus.ex_valid          = ex_valid_q;
   assign bus.ex_ctrl           = ex_ctrl_q;
   assign bus.ex_rs             = ex_rs_q;
   assign bus.ex_rt             = ex_rt_q;
   assign bus.ex_rd             = ex_rd_q;
   assign bus.ex_write_register = ex_wr_q;
   assign bus.ex_read_data1     = ex_rd1_q;
   assign bus.ex_read_data2     = ex_rd2_q;
   assign bus.ex_imm_ext        = ex_imm_q;
   assign bus.ex_pc_plus4       = ex_pc4_q;

`ifdef ID_EX_PERF_EN
   // ---------------- performance counters ----------------
   logic [31:0] bubble_cnt_q;
   logic [31:0] flush_cnt_q;
   logic        bubble_evt;
   logic        flush_evt;

   // A bubble chosen without a flush can only come from a load-use; neither
   // event is counted while EX is stalled.
   always_comb begin
      bubble_evt = (cap_sel == CAP_BUBBLE) & ~bus.flush_in;
      flush_evt  = bus.flush_in & bus.id_valid & ~bus.ex_stall_in;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bubble_cnt_q <= '0;
         flush_cnt_q  <= '0;
      end else begin
         if (bubble_evt && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
            bubble_cnt_q <= bubble_cnt_q + 32'd1;
         end
         if (flush_evt && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_q <= flush_cnt_q + 32'd1;
         end
      end
   end

   assign bus.perf_bubble_cnt = bubble_cnt_q;
   assign bus.perf_flush_cnt  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb_id_ex_stage_reg: self-checking bench for the ID/EX stage register.
// Table of directed vectors, hand sequences for stall/reset/perf, then random traffic vs a reference model.
module tb_id_ex_stage_reg;
   import mips_pkg::*;

   localparam int DATA_W = 32;
   localparam int REG_AW = 5;

   localparam ex_ctrl_t C_LW = '{reg_write:1'b1, mem_to_reg:1'b1, mem_read:1'b1, mem_write:1'b0,
                                 branch:1'b0, alu_src:1'b1, reg_dst:1'b0, alu_op:ALUOP_ADD};
   localparam ex_ctrl_t C_SW = '{reg_write:1'b0, mem_to_reg:1'b0, mem_read:1'b0, mem_write:1'b1,
                                 branch:1'b0, alu_src:1'b1, reg_dst:1'b0, alu_op:ALUOP_ADD};
   localparam ex_ctrl_t C_R  = '{reg_write:1'b1, mem_to_reg:1'b0, mem_read:1'b0, mem_write:1'b0,
                                 branch:1'b0, alu_src:1'b0, reg_dst:1'b1, alu_op:ALUOP_RTYPE};
   localparam ex_ctrl_t C_AI = '{reg_write:1'b1, mem_to_reg:1'b0, mem_read:1'b0, mem_write:1'b0,
                                 branch:1'b0, alu_src:1'b1, reg_dst:1'b0, alu_op:ALUOP_ADD};
   localparam ex_ctrl_t C_0  = '0;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   id_ex_stage_reg_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();

   id_ex_stage_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input ex_ctrl_t c, input logic ur,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] imm, input logic [31:0] pc,
                        input logic fl, input logic st);
      bus.id_valid      = v;
      bus.id_ctrl       = c;
      bus.id_uses_rt    = ur;
      bus.id_rs         = rs;
      bus.id_rt         = rt;
      bus.id_rd         = rd;
      bus.id_read_data1 = d1;
      bus.id_read_data2 = d2;
      bus.id_imm_ext    = imm;
      bus.id_pc_plus4   = pc;
      bus.flush_in      = fl;
      bus.ex_stall_in   = st;
   endtask

   task automatic idle();
      drive(1'b0, C_0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
   endtask

   // Leaves time at posedge+1 with rst released and EX empty.
   task automatic do_reset();
      idle();
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic       v;
      ex_ctrl_t   c;
      logic       ur;
      logic [4:0] rs, rt, rd;
      logic       fl, st;
      logic       e_hs;
      logic       e_v;
      ex_ctrl_t   e_c;
      logic [4:0] e_wr;
   } vec_t;

   function automatic vec_t mk(input logic v, input ex_ctrl_t c, input logic ur,
                               input int rs, input int rt, input int rd,
                               input logic fl, input logic st,
                               input logic ehs, input logic ev, input ex_ctrl_t ec, input int ewr);
      vec_t r;
      r.v = v; r.c = c; r.ur = ur;
      r.rs = 5'(rs); r.rt = 5'(rt); r.rd = 5'(rd);
      r.fl = fl; r.st = st;
      r.e_hs = ehs; r.e_v = ev; r.e_c = ec; r.e_wr = 5'(ewr);
      return r;
   endfunction

   vec_t tbl [25];

   // ---------------- reference model ----------------
   typedef struct {
      logic        v;
      ex_ctrl_t    c;
      logic [4:0]  rs, rt, rd, wr;
      logic [31:0] d1, d2, imm, pc;
   } ex_slot_t;

   ex_slot_t m;
   longint   m_bubbles;
   longint   m_flushes;

   function automatic logic model_load_use(input logic v, input logic ur,
                                           input logic [4:0] rs, input logic [4:0] rt);
      return m.v && m.c.mem_read && (m.rt != 5'd0) && v &&
             ((m.rt == rs) || (ur && (m.rt == rt)));
   endfunction

   initial begin
      logic [31:0] d1, d2, imm, pc;

      tbl[0]  = mk(1, C_LW, 0,  1,  8, 0, 0, 0, 0, 1, C_LW, 8);  // lw $8
      tbl[1]  = mk(1, C_R,  1,  8, 10, 9, 0, 0, 1, 0, C_0,  0);  // add $9,$8,$10 -> bubble
      tbl[2]  = mk(1, C_R,  1,  8, 10, 9, 0, 0, 0, 1, C_R,  9);  // add goes through
      tbl[3]  = mk(1, C_LW, 0,  1,  0, 0, 0, 0, 0, 1, C_LW, 0);  // lw $0
      tbl[4]  = mk(1, C_R,  1,  0,  1, 9, 0, 0, 0, 1, C_R,  9);  // add $9,$0,$1: no hazard
      tbl[5]  = mk(1, C_LW, 0,  2,  8, 0, 0, 0, 0, 1, C_LW, 8);  // lw $8
      tbl[6]  = mk(1, C_AI, 0, 10,  8, 0, 0, 0, 0, 1, C_AI, 8);  // addi $8,$10,4: rt not read
      tbl[7]  = mk(1, C_LW, 0,  3,  8, 0, 0, 0, 0, 1, C_LW, 8);  // EX not a load
      tbl[8]  = mk(1, C_SW, 1,  2,  8, 0, 0, 0, 1, 0, C_0,  0);  // sw $8: hazard via rt
      tbl[9]  = mk(1, C_SW, 1,  2,  8, 0, 0, 0, 0, 1, C_SW, 8);
      tbl[10] = mk(1, C_LW, 0,  1,  8, 0, 0, 0, 0, 1, C_LW, 8);
      tbl[11] = mk(1, C_R,  1,  8, 10, 9, 1, 1, 0, 0, C_0,  0);  // flush beats stall
      tbl[12] = mk(1, C_LW, 0,  1,  8, 0, 0, 0, 0, 1, C_LW, 8);
      tbl[13] = mk(1, C_R,  1,  8, 10, 9, 0, 1, 1, 1, C_LW, 8);  // stall holds lw
      tbl[14] = mk(1, C_R,  1,  8, 10, 9, 0, 0, 1, 0, C_0,  0);  // bubble
      tbl[15] = mk(1, C_R,  1,  8, 10, 9, 0, 1, 1, 0, C_0,  0);  // stall while bubbled
      tbl[16] = mk(1, C_R,  1,  8, 10, 9, 0, 0, 0, 1, C_R,  9);  // exactly one bubble
      tbl[17] = mk(0, C_R,  1,  8, 10, 9, 0, 0, 0, 0, C_0,  0);  // id_valid=0 -> bubble
      tbl[18] = mk(1, C_LW, 0,  1,  8, 0, 0, 0, 0, 1, C_LW, 8);
      tbl[19] = mk(0, C_R,  1,  8, 10, 9, 0, 0, 0, 0, C_0,  0);  // invalid ID never hazards
      tbl[20] = mk(1, C_LW, 0,  1,  8, 0, 0, 0, 0, 1, C_LW, 8);
      tbl[21] = mk(1, C_R,  1,  8, 10, 9, 0, 0, 1, 0, C_0,  0);
      tbl[22] = mk(1, C_R,  1,  8, 10, 9, 1, 0, 0, 0, C_0,  0);  // flush during bubble
      tbl[23] = mk(1, C_LW, 0,  4,  8, 0, 0, 0, 0, 1, C_LW, 8);
      tbl[24] = mk(1, C_R,  1,  9,  8, 9, 0, 0, 1, 0, C_0,  0);  // hazard via rt

      // ---------- reset state (stall requested during reset) ----------
      idle();
      bus.ex_stall_in = 1'b1;
      rst = 1'b1;
      #12;
      check("reset_hazard_stall", bus.hazard_stall, 1'b0);
      check("reset_ex_valid", bus.ex_valid, 1'b0);
      check("reset_ex_ctrl", bus.ex_ctrl, C_0);
      check("reset_read_data1", bus.ex_read_data1, 32'd0);
      check("reset_pc_plus4", bus.ex_pc_plus4, 32'd0);
      check("reset_write_reg", bus.ex_write_register, 5'd0);
      bus.ex_stall_in = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;

      // ---------- table ----------
      foreach (tbl[i]) begin
         drive(tbl[i].v, tbl[i].c, tbl[i].ur, tbl[i].rs, tbl[i].rt, tbl[i].rd,
               $urandom, $urandom, $urandom, $urandom, tbl[i].fl, tbl[i].st);
         #3;
         check($sformatf("tbl%0d_hazard_stall", i), bus.hazard_stall, tbl[i].e_hs);
         @(posedge clk);
         #1;
         check($sformatf("tbl%0d_ex_valid", i), bus.ex_valid, tbl[i].e_v);
         check($sformatf("tbl%0d_ex_ctrl", i), bus.ex_ctrl, tbl[i].e_c);
         if (tbl[i].e_v) begin
            check($sformatf("tbl%0d_write_reg", i), bus.ex_write_register, tbl[i].e_wr);
         end
      end

      // ---------- downstream stall for 3 cycles ----------
      do_reset();
      drive(1'b1, C_LW, 1'b0, 5'd3, 5'd8, 5'd0, 32'h1111_0001, 32'h2222_0002,
            32'h0000_0010, 32'h0040_0004, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, C_R, 1'b1, 5'd5, 5'd6, 5'd7, $urandom, $urandom, $urandom, $urandom, 1'b0, 1'b1);
         #3;
         check("stall_hazard_stall", bus.hazard_stall, 1'b1);
         @(posedge clk);
         #1;
         check("stall_ex_valid", bus.ex_valid, 1'b1);
         check("stall_ex_ctrl", bus.ex_ctrl, C_LW);
         check("stall_read_data1", bus.ex_read_data1, 32'h1111_0001);
         check("stall_read_data2", bus.ex_read_data2, 32'h2222_0002);
         check("stall_imm", bus.ex_imm_ext, 32'h0000_0010);
         check("stall_pc", bus.ex_pc_plus4, 32'h0040_0004);
         check("stall_rt", bus.ex_rt, 5'd8);
      end
      drive(1'b1, C_R, 1'b1, 5'd5, 5'd6, 5'd7, 32'hAAAA_0001, 32'hBBBB_0002,
            32'd0, 32'h0040_0008, 1'b0, 1'b0);
      #3;
      check("resume_hazard_stall", bus.hazard_stall, 1'b0);
      @(posedge clk);
      #1;
      check("resume_ex_ctrl", bus.ex_ctrl, C_R);
      check("resume_read_data1", bus.ex_read_data1, 32'hAAAA_0001);
      check("resume_write_reg", bus.ex_write_register, 5'd7);

      // ---------- async reset in the middle of a load-use stall ----------
      drive(1'b1, C_LW, 1'b0, 5'd1, 5'd8, 5'd0, 32'h5, 32'h6, 32'h7, 32'h8, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      drive(1'b1, C_R, 1'b1, 5'd8, 5'd10, 5'd9, 32'h9, 32'hA, 32'hB, 32'hC, 1'b0, 1'b0);
      #2;
      check("pre_reset_hazard_stall", bus.hazard_stall, 1'b1);
      rst = 1'b1;
      #1;
      check("midrst_hazard_stall", bus.hazard_stall, 1'b0);
      check("midrst_ex_valid", bus.ex_valid, 1'b0);
      check("midrst_ex_ctrl", bus.ex_ctrl, C_0);
      check("midrst_read_data2", bus.ex_read_data2, 32'd0);
      check("midrst_rt", bus.ex_rt, 5'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      #2;
      check("postrst_hazard_stall", bus.hazard_stall, 1'b0);
      @(posedge clk);
      #1;
      check("postrst_ex_ctrl", bus.ex_ctrl, C_R);

`ifdef ID_EX_PERF_EN
      // ---------- perf counters: 5 load-use bubbles, 2 counted flushes ----------
      do_reset();
      for (int k = 0; k < 5; k++) begin
         drive(1'b1, C_LW, 1'b0, 5'd1, 5'd8, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
         @(posedge clk); #1;
         drive(1'b1, C_R, 1'b1, 5'd8, 5'd2, 5'd9, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
         @(posedge clk); #1;   // bubble
         @(posedge clk); #1;   // add enters EX
      end
      drive(1'b1, C_R, 1'b1, 5'd1, 5'd2, 5'd3, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
      @(posedge clk); #1;
      drive(1'b0, C_R, 1'b1, 5'd1, 5'd2, 5'd3, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
      @(posedge clk); #1;      // invalid ID: not counted
      drive(1'b1, C_R, 1'b1, 5'd1, 5'd2, 5'd3, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1);
      @(posedge clk); #1;      // stalled: not counted
      drive(1'b1, C_R, 1'b1, 5'd1, 5'd2, 5'd3, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
      @(posedge clk); #1;
      idle();
      check("perf_bubble_cnt", bus.perf_bubble_cnt, 32'd5);
      check("perf_flush_cnt", bus.perf_flush_cnt, 32'd2);
`endif

      // ---------- random traffic against the reference model ----------
      do_reset();
      m = '{v:1'b0, c:C_0, rs:5'd0, rt:5'd0, rd:5'd0, wr:5'd0,
            d1:32'd0, d2:32'd0, imm:32'd0, pc:32'd0};
      m_bubbles = 0;
      m_flushes = 0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         logic v, ur, fl, st, lu, exp_hs;
         ex_ctrl_t c;
         logic [4:0] rs, rt, rd;
         v  = ($urandom_range(0, 99) < 85);
         c  = ex_ctrl_t'($urandom_range(0, 511));
         c.mem_read = ($urandom_range(0, 9) < 4);
         ur = $urandom_range(0, 1);
         rs = 5'($urandom_range(0, 3));
         rt = 5'($urandom_range(0, 3));
         rd = 5'($urandom_range(0, 3));
         fl = ($urandom_range(0, 99) < 8);
         st = ($urandom_range(0, 99) < 15);
         d1 = $urandom; d2 = $urandom; imm = $urandom; pc = $urandom;
         drive(v, c, ur, rs, rt, rd, d1, d2, imm, pc, fl, st);

         lu     = model_load_use(v, ur, rs, rt);
         exp_hs = fl ? 1'b0 : (st ? 1'b1 : lu);
         #3;
         check("rnd_hazard_stall", bus.hazard_stall, exp_hs);

         // Next EX contents: flush or load-use empties the slot, stall keeps it,
         // anything else takes the ID instruction (empty if id_valid=0).
         if (fl || (!st && lu)) begin
            m.v = 1'b0;
            m.c = C_0;
            if (!fl) m_bubbles++;
            if (fl && v && !st) m_flushes++;
         end else if (!st) begin
            m.v   = v;
            m.c   = v ? c : C_0;
            m.rs  = rs;  m.rt = rt;  m.rd = rd;
            m.wr  = c.reg_dst ? rd : rt;
            m.d1  = d1;  m.d2 = d2;  m.imm = imm;  m.pc = pc;
         end

         @(posedge clk);
         #1;
         check("rnd_ex_valid", bus.ex_valid, m.v);
         check("rnd_ex_ctrl", bus.ex_ctrl, m.c);
         if (m.v) begin
            check("rnd_rs", bus.ex_rs, m.rs);
            check("rnd_rt", bus.ex_rt, m.rt);
            check("rnd_rd", bus.ex_rd, m.rd);
            check("rnd_write_reg", bus.ex_write_register, m.wr);
            check("rnd_read_data1", bus.ex_read_data1, m.d1);
            check("rnd_read_data2", bus.ex_read_data2, m.d2);
            check("rnd_imm", bus.ex_imm_ext, m.imm);
            check("rnd_pc_plus4", bus.ex_pc_plus4, m.pc);
         end
      end
      idle();
`ifdef ID_EX_PERF_EN
      check("rnd_perf_bubble_cnt", bus.perf_bubble_cnt, 32'(m_bubbles));
      check("rnd_perf_flush_cnt", bus.perf_flush_cnt, 32'(m_flushes));
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
